// File: rtl/top_if.sv
// Instruction-fetch stage: PC, instruction memory, IF/ID registers, halt
// detection and run-cycle counter for the debug unit.
module top_if #(
  parameter int                        LENGTH_INSTRUCTION = 32,
  parameter int                        CANT_BITS_ADDR     = 11,
  parameter int                        CANT_BITS_CONTADOR = 32,
  parameter logic [LENGTH_INSTRUCTION-1:0] HALT_INSTRUCTION = 32'hFFFFFFFF
) (
  input  logic                          i_clock,
  input  logic                          i_soft_reset,
  input  logic                          i_enable_pipeline,
  input  logic                          i_stall,
  input  logic                          i_branch_control,
  input  logic [CANT_BITS_ADDR-1:0]     i_branch_dir,
  input  logic                          i_write_enable_mem,
  input  logic [CANT_BITS_ADDR-1:0]     i_addr_mem_write,
  input  logic [LENGTH_INSTRUCTION-1:0] i_data_mem_write,
  output logic [LENGTH_INSTRUCTION-1:0] o_instruction,
  output logic [CANT_BITS_ADDR-1:0]     o_out_adder_pc,
  output logic [CANT_BITS_ADDR-1:0]     o_pc,
  output logic                          o_halt_detected,
  output logic [CANT_BITS_CONTADOR-1:0] o_contador_ciclos
);

  localparam int DEPTH = 1 << CANT_BITS_ADDR;

  logic [LENGTH_INSTRUCTION-1:0] mem [DEPTH];

  logic [CANT_BITS_ADDR-1:0]     pc_q, pc_d;
  logic [LENGTH_INSTRUCTION-1:0] instr_q, instr_d;
  logic [CANT_BITS_ADDR-1:0]     adder_q, adder_d;
  logic                          halt_q, halt_d;
  logic [CANT_BITS_CONTADOR-1:0] cnt_q, cnt_d;

  logic [LENGTH_INSTRUCTION-1:0] fetchWord;
  logic [CANT_BITS_ADDR-1:0]     pcPlusOne;
  logic                          adv;

  assign fetchWord = mem[pc_q];
  assign pcPlusOne = pc_q + CANT_BITS_ADDR'(1);
  assign adv       = i_enable_pipeline & ~i_stall & ~halt_q;

  // Program load only while the pipeline is stopped, so reads and writes never collide.
  always_ff @(posedge i_clock) begin
    if (i_write_enable_mem && !i_enable_pipeline && !i_soft_reset) begin
      mem[i_addr_mem_write] <= i_data_mem_write;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    adder_d = adder_q;
    halt_d  = halt_q;
    cnt_d   = cnt_q;
    if (i_enable_pipeline && !halt_q) begin
      cnt_d = cnt_q + CANT_BITS_CONTADOR'(1);
    end
    // Once halted, keep feeding NOPs so the downstream stages drain.
    if (i_enable_pipeline && halt_q) begin
      instr_d = '0;
    end else if (adv) begin
      instr_d = fetchWord;
      adder_d = pcPlusOne;
      if (fetchWord == HALT_INSTRUCTION) begin
        halt_d = 1'b1;
      end else begin
        pc_d = i_branch_control ? i_branch_dir : pcPlusOne;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_soft_reset) begin
      pc_q    <= '0;
      instr_q <= '0;
      adder_q <= '0;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      adder_q <= adder_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_instruction     = instr_q;
  assign o_out_adder_pc    = adder_q;
  assign o_pc              = pc_q;
  assign o_halt_detected   = halt_q;
  assign o_contador_ciclos = cnt_q;

endmodule

// File: tb/tb_top_if.sv
// Scoreboard bench for top_if: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the fetch outputs.
module tb_top_if;

  logic        clk;
  logic        rst;
  logic        en;
  logic        stall;
  logic        br;
  logic [10:0] dir;
  logic        we;
  logic [10:0] wa;
  logic [31:0] wd;
  logic [31:0] instr;
  logic [10:0] adder;
  logic [10:0] pc;
  logic        halt;
  logic [31:0] cnt;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [10:0] adder;
    logic [10:0] pc;
    logic        halt;
    logic [31:0] cnt;
  } expect_t;

  expect_t scoreQ[$];
  int total = 0;
  int bad   = 0;

  top_if dut (
    .i_clock           (clk),
    .i_soft_reset      (rst),
    .i_enable_pipeline (en),
    .i_stall           (stall),
    .i_branch_control  (br),
    .i_branch_dir      (dir),
    .i_write_enable_mem(we),
    .i_addr_mem_write  (wa),
    .i_data_mem_write  (wd),
    .o_instruction     (instr),
    .o_out_adder_pc    (adder),
    .o_pc              (pc),
    .o_halt_detected   (halt),
    .o_contador_ciclos (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; the monitor samples on the falling edge.
  task automatic applyStimulus(input logic r, input logic e, input logic s,
                               input logic b, input logic [10:0] d);
    rst = r; en = e; stall = s; br = b; dir = d;
    @(posedge clk); #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] i,
                             input logic [10:0] a, input logic [10:0] p,
                             input logic h, input logic [31:0] c);
    expect_t x;
    x.name = name; x.instr = i; x.adder = a; x.pc = p; x.halt = h; x.cnt = c;
    scoreQ.push_back(x);
  endtask

  task automatic loadWord(input logic [10:0] addr, input logic [31:0] data);
    we = 1'b1; wa = addr; wd = data;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
    we = 1'b0;
  endtask

  always @(negedge clk) begin
    if (scoreQ.size() > 0) begin
      expect_t x;
      x = scoreQ.pop_front();
      total++;
      if (instr !== x.instr || adder !== x.adder || pc !== x.pc ||
          halt !== x.halt || cnt !== x.cnt) begin
        bad++;
        $display("[TB] FAIL %s: got instr=%h adder=%h pc=%h halt=%b cnt=%0d, want instr=%h adder=%h pc=%h halt=%b cnt=%0d",
                 x.name, instr, adder, pc, halt, cnt, x.instr, x.adder, x.pc, x.halt, x.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; stall = 1'b0; br = 1'b0; dir = '0;
    we = 1'b0; wa = '0; wd = '0;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 11'd0);
    checkOutput("reset", 32'h0, 11'h0, 11'h0, 1'b0, 32'd0);

    // Fill memory with mem[a]=a so every fetched word is known, then place the program.
    for (int i = 0; i < 2048; i++) loadWord(11'(i), 32'(i));
    loadWord(11'd0, 32'h20010005);
    loadWord(11'd1, 32'h20020003);
    loadWord(11'd2, 32'h00221820);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
    checkOutput("load_hold", 32'h0, 11'h0, 11'h0, 1'b0, 32'd0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    checkOutput("seq_e1", 32'h20010005, 11'd1, 11'd1, 1'b0, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    checkOutput("seq_e2", 32'h20020003, 11'd2, 11'd2, 1'b0, 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    checkOutput("seq_e3", 32'h00221820, 11'd3, 11'd3, 1'b0, 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 11'h010);
    checkOutput("branch_slot", 32'h3, 11'd4, 11'h010, 1'b0, 32'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    checkOutput("branch_target", 32'h10, 11'h011, 11'h011, 1'b0, 32'd5);

    // Restart and run to pc=5 for the stall case.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 11'd0);
    checkOutput("reset2", 32'h0, 11'h0, 11'h0, 1'b0, 32'd0);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    checkOutput("pre_stall", 32'h4, 11'd5, 11'd5, 1'b0, 32'd5);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 11'h020);
    checkOutput("stall_1", 32'h4, 11'd5, 11'd5, 1'b0, 32'd6);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 11'h020);
    checkOutput("stall_2", 32'h4, 11'd5, 11'd5, 1'b0, 32'd7);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    checkOutput("post_stall", 32'h5, 11'd6, 11'd6, 1'b0, 32'd8);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 11'h030);
    checkOutput("reset_midrun", 32'h0, 11'h0, 11'h0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    checkOutput("after_reset", 32'h20010005, 11'd1, 11'd1, 1'b0, 32'd1);

    // Write strobe while running must not reach memory.
    we = 1'b1; wa = 11'd7; wd = 32'hDEADBEEF;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    we = 1'b0;
    checkOutput("gated_write_edge", 32'h20020003, 11'd2, 11'd2, 1'b0, 32'd2);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    checkOutput("pre_fetch7", 32'h6, 11'd7, 11'd7, 1'b0, 32'd7);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    checkOutput("mem7_unchanged", 32'h7, 11'd8, 11'd8, 1'b0, 32'd8);

    loadWord(11'd8, 32'h12345678);
    checkOutput("disabled_hold", 32'h7, 11'd8, 11'd8, 1'b0, 32'd8);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    checkOutput("write_visible", 32'h12345678, 11'd9, 11'd9, 1'b0, 32'd9);

    // Halt at address 4, with a branch request on the halt edge.
    loadWord(11'd4, 32'hFFFFFFFF);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 11'd0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    checkOutput("pre_halt", 32'h3, 11'd4, 11'd4, 1'b0, 32'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 11'h030);
    checkOutput("halt_edge", 32'hFFFFFFFF, 11'd5, 11'd4, 1'b1, 32'd5);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
      checkOutput("halt_drain", 32'h0, 11'd5, 11'd4, 1'b1, 32'd5);
    end

    // Walk the PC across the top of the address space.
    loadWord(11'd4, 32'h4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 11'd0);
    checkOutput("reset_from_halt", 32'h0, 11'h0, 11'h0, 1'b0, 32'd0);
    repeat (2046) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    checkOutput("pc_top", 32'h7FE, 11'h7FF, 11'h7FF, 1'b0, 32'd2047);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    checkOutput("pc_wrap", 32'h7FF, 11'h000, 11'h000, 1'b0, 32'd2048);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    checkOutput("after_wrap", 32'h20010005, 11'd1, 11'd1, 1'b0, 32'd2049);

    for (int w = 0; w < 10 && scoreQ.size() > 0; w++) @(posedge clk);
    if (scoreQ.size() > 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending, want 0", scoreQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
